kpscan: RTL and testbench



---
 rtl/kpscan_pkg.sv | 47 ++++
 rtl/kpscan_stable_timer.sv | 26 ++
 rtl/kpscan.sv | 189 ++++++++++++++++++
 tb/tb_kpscan.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kpscan_pkg.sv
// kpscan shared types, default parameters and row-decode helper.
// Imported by the keypad scanner top level.
package kpscan_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kpscan_state_t;

  localparam int DEF_NCOLS    = 4;
  localparam int DEF_NROWS    = 4;
  localparam int DEF_SCAN_DIV = 1000;
  localparam int DEF_DEBOUNCE = 50000;

  // Widest row vector the decode helper accepts.
  localparam int MAXR = 32;

  typedef struct packed {
    logic [4:0] idx;
    logic       multi;
  } oh_t;

  // Position of the first set bit counted from bit n-1 downward,
  // plus a flag when more than one bit is set.
  function automatic oh_t onehot_index(
    input logic [MAXR-1:0] lows,
    input int              n
  );
    oh_t  res;
    logic found;
    res   = '0;
    found = 1'b0;
    for (int j = MAXR - 1; j >= 0; j--) begin
      if (j < n && lows[j]) begin
        if (found) begin
          res.multi = 1'b1;
        end else begin
          res.idx = 5'(n - 1 - j);
          found   = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/kpscan_stable_timer.sv
// Shared dwell / stability counter for the keypad scanner.
// Clear wins over enable; tc compares against a run-time limit.
module kp_stable_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [TW-1:0] i_limit,
  output logic          o_tc
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == i_limit);

endmodule

// File: rtl/kpscan.sv
// Keypad matrix scanner: column sweep, press debounce, key encode,
// and release tracking with one shared stability timer.
module kpscan
  import kpscan_pkg::*;
#(
  parameter int NCOLS    = DEF_NCOLS,
  parameter int NROWS    = DEF_NROWS,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NROWS-1:0]               kpr,
  output logic [NCOLS-1:0]               kpc,
  output logic                           key_valid,
  output logic [$clog2(NROWS*NCOLS)-1:0] key_code,
  output logic                           key_held,
  output logic                           key_multi
);

  localparam int CW   = $clog2(NROWS * NCOLS);
  localparam int TMAX = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CLW  = $clog2(NCOLS);

  kpscan_state_t r_state;
  kpscan_state_t w_nxt;

  logic [CLW-1:0]   r_col;
  logic [NCOLS-1:0] r_kpc;
  logic [NROWS-1:0] r_snap;
  logic             r_valid;
  logic             r_multi;
  logic             r_held;
  logic [CW-1:0]    r_code;

  logic             w_tc;
  logic             w_idle;
  logic             w_match;
  logic             w_clr;
  logic             w_en;
  logic             w_adv;
  logic             w_load;
  logic             w_accept;
  logic [TW-1:0]    w_limit;
  logic [CLW-1:0]   w_col_nxt;
  logic [NCOLS-1:0] w_kpc_nxt;
  logic [MAXR-1:0]  w_lows;
  oh_t              w_oh;
  logic [CW-1:0]    w_code;

  assign w_idle  = &kpr;
  assign w_match = (kpr == r_snap);

  // Dwell limit while scanning, stability limit otherwise.
  assign w_limit = (r_state == SCAN) ? TW'(SCAN_DIV - 1)
                                     : TW'(DEBOUNCE - 1);

  kp_stable_timer #(
    .TW(TW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .i_limit(w_limit),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SCAN;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Enum literal is scoped: the bare name is the parameter here.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      SCAN: begin
        if (w_tc && !w_idle) w_nxt = kpscan_pkg::DEBOUNCE;
      end
      kpscan_pkg::DEBOUNCE: begin
        if (!w_match)  w_nxt = SCAN;
        else if (w_tc) w_nxt = HELD;
      end
      HELD: begin
        if (w_idle && w_tc) w_nxt = SCAN;
      end
      default: w_nxt = SCAN;
    endcase
  end

  always_comb begin
    w_clr    = 1'b0;
    w_en     = 1'b0;
    w_adv    = 1'b0;
    w_load   = 1'b0;
    w_accept = 1'b0;
    unique case (r_state)
      SCAN: begin
        if (w_tc) begin
          w_clr  = 1'b1;
          w_adv  = w_idle;
          w_load = !w_idle;
        end else begin
          w_en = 1'b1;
        end
      end
      kpscan_pkg::DEBOUNCE: begin
        if (!w_match) begin
          w_clr = 1'b1;
        end else if (w_tc) begin
          w_clr    = 1'b1;
          w_accept = 1'b1;
        end else begin
          w_en = 1'b1;
        end
      end
      HELD: begin
        if (!w_idle) begin
          w_clr = 1'b1;
        end else if (w_tc) begin
          w_clr = 1'b1;
          w_adv = 1'b1;
        end else begin
          w_en = 1'b1;
        end
      end
      default: w_clr = 1'b1;
    endcase
  end

  always_comb begin
    w_col_nxt = r_col;
    if (w_adv) begin
      w_col_nxt = (r_col == CLW'(NCOLS - 1)) ? '0 : r_col + 1'b1;
    end
  end

  always_comb begin
    w_kpc_nxt = '1;
    for (int i = 0; i < NCOLS; i++) begin
      w_kpc_nxt[i] = (i != NCOLS - 1 - int'(w_col_nxt));
    end
  end

  // At accept time kpr equals snap, so snap drives the decode.
  always_comb begin
    w_lows              = '0;
    w_lows[NROWS-1:0]   = ~r_snap;
  end

  assign w_oh   = onehot_index(w_lows, NROWS);
  assign w_code = CW'(int'(w_oh.idx) * NCOLS + int'(r_col));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col   <= '0;
      r_kpc   <= {1'b0, {(NCOLS-1){1'b1}}};
      r_snap  <= '1;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
      r_held  <= 1'b0;
      r_code  <= '0;
    end else begin
      r_col   <= w_col_nxt;
      r_kpc   <= w_kpc_nxt;
      r_valid <= w_accept && !w_oh.multi;
      r_multi <= w_accept && w_oh.multi;
      r_held  <= (w_nxt == HELD);
      if (w_load) begin
        r_snap <= kpr;
      end
      if (w_accept && !w_oh.multi) begin
        r_code <= w_code;
      end
    end
  end

  assign kpc       = r_kpc;
  assign key_valid = r_valid;
  assign key_multi = r_multi;
  assign key_held  = r_held;
  assign key_code  = r_code;

endmodule

// File: tb/tb_kpscan.sv
// Directed self-checking bench for kpscan (4x4, SCAN_DIV=4, DEBOUNCE=8).
// Inputs change on the falling edge; outputs are sampled there too.
module tb_kpscan;

  logic       clk;
  logic       reset;
  logic [3:0] kpr;
  logic [3:0] kpc;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic       key_multi;

  int errors = 0;
  int checks = 0;

  kpscan #(
    .NCOLS   (4),
    .NROWS   (4),
    .SCAN_DIV(4),
    .DEBOUNCE(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .kpr      (kpr),
    .kpc      (kpc),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held),
    .key_multi(key_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic wait_kpc(input logic [3:0] want);
    int n;
    n = 0;
    while (kpc !== want && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (kpc !== want) begin
      errors++;
      $display("FAIL wait_kpc got=%b exp=%b", kpc, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    kpr   = 4'b1111;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (kpc !== 4'b0111) begin
      errors++;
      $display("FAIL reset_kpc got=%b exp=0111", kpc);
    end
    checks++;
    if ({key_valid, key_held, key_multi} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=000",
               {key_valid, key_held, key_multi});
    end
    checks++;
    if (key_code !== 4'd0) begin
      errors++;
      $display("FAIL reset_code got=%0d exp=0", key_code);
    end
  endtask

  task automatic test_idle_sweep();
    logic [3:0] exp;
    kpr = 4'b1111;
    for (int t = 0; t < 17; t++) begin
      exp = 4'b1111;
      exp[3 - (t / 4) % 4] = 1'b0;
      checks++;
      if (kpc !== exp) begin
        errors++;
        $display("FAIL sweep_kpc t=%0d got=%b exp=%b", t, kpc, exp);
      end
      checks++;
      if ({key_valid, key_held, key_multi} !== 3'b000) begin
        errors++;
        $display("FAIL sweep_flags t=%0d got=%b exp=000",
                 t, {key_valid, key_held, key_multi});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clean_press();
    wait_kpc(4'b1011);
    kpr = 4'b1101;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      if (n < 12) begin
        checks++;
        if (key_valid !== 1'b0 || kpc !== 4'b1011) begin
          errors++;
          $display("FAIL press_wait n=%0d valid=%b kpc=%b exp 0/1011",
                   n, key_valid, kpc);
        end
      end else if (n == 12) begin
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd9) begin
          errors++;
          $display("FAIL press_pulse valid=%b code=%0d exp 1/9",
                   key_valid, key_code);
        end
        checks++;
        if (key_held !== 1'b1 || key_multi !== 1'b0 || kpc !== 4'b1011) begin
          errors++;
          $display("FAIL press_state held=%b multi=%b kpc=%b exp 1/0/1011",
                   key_held, key_multi, kpc);
        end
      end else begin
        checks++;
        if (key_valid !== 1'b0 || key_held !== 1'b1) begin
          errors++;
          $display("FAIL press_width valid=%b held=%b exp 0/1",
                   key_valid, key_held);
        end
      end
    end
  endtask

  task automatic test_release();
    for (int m = 0; m < 16; m++) begin
      kpr = (m == 7) ? 4'b1101 : 4'b1111;
      @(negedge clk);
      if (m + 1 < 16) begin
        checks++;
        if (key_held !== 1'b1 || kpc !== 4'b1011 || key_valid !== 1'b0) begin
          errors++;
          $display("FAIL release_hold m=%0d held=%b kpc=%b valid=%b",
                   m + 1, key_held, kpc, key_valid);
        end
      end
    end
    checks++;
    if (key_held !== 1'b0 || kpc !== 4'b1101) begin
      errors++;
      $display("FAIL release_exit held=%b kpc=%b exp 0/1101",
               key_held, kpc);
    end
    checks++;
    if (key_code !== 4'd9) begin
      errors++;
      $display("FAIL release_code got=%0d exp=9", key_code);
    end
  endtask

  task automatic test_bounce();
    int n;
    wait_kpc(4'b1011);
    kpr = 4'b1101;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (i == 10) begin
        checks++;
        if (key_held !== 1'b0 || kpc !== 4'b1011) begin
          errors++;
          $display("FAIL bounce_scan held=%b kpc=%b exp 0/1011",
                   key_held, kpc);
        end
      end
      if (i < 22) begin
        checks++;
        if (key_valid !== 1'b0) begin
          errors++;
          $display("FAIL bounce_nopulse n=%0d got=%b exp=0", i, key_valid);
        end
      end else begin
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd9) begin
          errors++;
          $display("FAIL bounce_retry valid=%b code=%0d exp 1/9",
                   key_valid, key_code);
        end
      end
      if (i == 9) kpr = 4'b1111;
      if (i == 10) kpr = 4'b1101;
    end
    kpr = 4'b1111;
    n = 0;
    while (key_held === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (key_held !== 1'b0 || kpc !== 4'b1101) begin
      errors++;
      $display("FAIL bounce_release held=%b kpc=%b exp 0/1101",
               key_held, kpc);
    end
  endtask

  task automatic test_multi();
    wait_kpc(4'b0111);
    kpr = 4'b0110;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      if (n < 12) begin
        checks++;
        if (key_multi !== 1'b0 || key_valid !== 1'b0) begin
          errors++;
          $display("FAIL multi_wait n=%0d multi=%b valid=%b exp 0/0",
                   n, key_multi, key_valid);
        end
      end else if (n == 12) begin
        checks++;
        if (key_multi !== 1'b1 || key_valid !== 1'b0) begin
          errors++;
          $display("FAIL multi_pulse multi=%b valid=%b exp 1/0",
                   key_multi, key_valid);
        end
        checks++;
        if (key_code !== 4'd9 || key_held !== 1'b1) begin
          errors++;
          $display("FAIL multi_state code=%0d held=%b exp 9/1",
                   key_code, key_held);
        end
      end else begin
        checks++;
        if (key_multi !== 1'b0 || kpc !== 4'b0111) begin
          errors++;
          $display("FAIL multi_width multi=%b kpc=%b exp 0/0111",
                   key_multi, kpc);
        end
      end
    end
  endtask

  task automatic test_reset_held();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (kpc !== 4'b0111 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL rst_held kpc=%b held=%b exp 0111/0", kpc, key_held);
    end
    checks++;
    if ({key_valid, key_multi} !== 2'b00 || key_code !== 4'd0) begin
      errors++;
      $display("FAIL rst_held_out vm=%b code=%0d exp 00/0",
               {key_valid, key_multi}, key_code);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_accept();
    kpr = 4'b1101;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 11) reset = 1'b1;
    end
    checks++;
    if ({key_valid, key_held, key_multi} !== 3'b000 || kpc !== 4'b0111) begin
      errors++;
      $display("FAIL rst_accept flags=%b kpc=%b exp 000/0111",
               {key_valid, key_held, key_multi}, kpc);
    end
    checks++;
    if (key_code !== 4'd0) begin
      errors++;
      $display("FAIL rst_accept_code got=%0d exp=0", key_code);
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n < 12) begin
        checks++;
        if (key_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_wait n=%0d valid=%b exp=0", n, key_valid);
        end
      end
    end
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'd8 || key_held !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pulse valid=%b code=%0d held=%b exp 1/8/1",
               key_valid, key_code, key_held);
    end
  endtask

  initial begin
    reset = 1'b1;
    kpr   = 4'b1111;
    test_reset();
    test_idle_sweep();
    test_clean_press();
    test_release();
    test_bounce();
    test_multi();
    test_reset_held();
    test_reset_accept();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
